// File: rtl/ibex_register_file_mp.sv
// Multi-port flip-flop register file: N read / M write ports, optional write-to-read
// bypass, per-register busy scoreboard with reserve handshake, flush and collision flag.
module ibex_register_file_mp #(
    parameter bit RV32E        = 1'b0,
    parameter int DataWidth    = 32,
    parameter int NumRead      = 2,
    parameter int NumWrite     = 2,
    parameter bit WriteBypass  = 1'b1,
    parameter bit ScoreboardEn = 1'b1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumRead*5-1:0]            raddr_i,
    output logic [NumRead*DataWidth-1:0]    rdata_o,
    output logic [NumRead-1:0]              rbusy_o,
    input  logic [NumWrite*5-1:0]           waddr_i,
    input  logic [NumWrite*DataWidth-1:0]   wdata_i,
    input  logic [NumWrite-1:0]             we_i,
    input  logic                            rsv_valid_i,
    input  logic [4:0]                      rsv_addr_i,
    output logic                            rsv_ready_o,
    input  logic                            flush_i,
    output logic                            wcoll_o
);

    localparam int NumRegs = RV32E ? 16 : 32;
    localparam int AddrW   = RV32E ? 4 : 5;

    logic [NumRegs-1:0]                reg_we;
    logic [NumRegs-1:0][DataWidth-1:0] reg_wd;
    logic [NumRegs-1:0][DataWidth-1:0] mem;
    logic [NumRegs-1:0]                busy;
    logic                              coll;
    logic                              wcoll_q;

    // Per-register write winner; later (higher-index) ports override earlier ones.
    // R0 and out-of-range addresses never match, so those writes are dropped.
    always_comb begin
        reg_we = '0;
        reg_wd = '0;
        for (int p = 0; p < NumWrite; p++) begin
            for (int r = 1; r < NumRegs; r++) begin
                if (we_i[p] && (waddr_i[5*p +: 5] == 5'(r))) begin
                    reg_we[r] = 1'b1;
                    reg_wd[r] = wdata_i[DataWidth*p +: DataWidth];
                end
            end
        end
    end

    assign mem[0] = '0;
    for (genvar r = 1; r < NumRegs; r++) begin : g_reg
        logic [DataWidth-1:0] q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i)          q <= '0;
            else if (reg_we[r]) q <= reg_wd[r];
        end
        assign mem[r] = q;
    end

    always_comb begin
        coll = 1'b0;
        for (int i = 0; i < NumWrite; i++) begin
            for (int j = i + 1; j < NumWrite; j++) begin
                if (we_i[i] && we_i[j] && (waddr_i[5*i +: 5] == waddr_i[5*j +: 5])) coll = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wcoll_q <= 1'b0;
        else       wcoll_q <= coll;
    end
    assign wcoll_o = wcoll_q;

    if (ScoreboardEn) begin : g_sb
        logic [AddrW-1:0] rsv_idx;
        logic             rsv_ok;
        logic             rsv_fire;

        assign rsv_idx = rsv_addr_i[AddrW-1:0];
        assign rsv_ok  = (!RV32E || !rsv_addr_i[4]) && (rsv_idx != '0);
        // A write landing this cycle frees the register, so a re-reserve may proceed.
        assign rsv_ready_o = rsv_valid_i & ~flush_i &
                             (~rsv_ok | ~busy[rsv_idx] | reg_we[rsv_idx]);
        assign rsv_fire    = rsv_ready_o & rsv_ok;

        assign busy[0] = 1'b0;
        for (genvar r = 1; r < NumRegs; r++) begin : g_busy
            logic b;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)                                  b <= 1'b0;
                else if (flush_i)                           b <= 1'b0;
                else if (rsv_fire && rsv_idx == AddrW'(r))  b <= 1'b1;
                else if (reg_we[r])                         b <= 1'b0;
            end
            assign busy[r] = b;
        end
    end else begin : g_nosb
        logic unused_sb;
        assign unused_sb   = ^{flush_i, rsv_addr_i};
        assign busy        = '0;
        assign rsv_ready_o = rsv_valid_i;
    end

    for (genvar k = 0; k < NumRead; k++) begin : g_rd
        logic [4:0]           a;
        logic [AddrW-1:0]     idx;
        logic                 ok;
        logic [DataWidth-1:0] d;
        logic                 b;

        assign a   = raddr_i[5*k +: 5];
        assign idx = a[AddrW-1:0];
        assign ok  = (!RV32E || !a[4]) && (idx != '0);

        always_comb begin
            d = '0;
            b = 1'b0;
            if (ok) begin
                if (WriteBypass && reg_we[idx]) begin
                    d = reg_wd[idx];
                end else begin
                    d = mem[idx];
                    b = busy[idx];
                end
            end
        end

        assign rdata_o[DataWidth*k +: DataWidth] = d;
        assign rbusy_o[k]                        = b;
    end

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Directed scoreboard bench: stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_ibex_register_file_mp;

    localparam int K_RDATA = 0, K_RBUSY = 1, K_RDY = 2, K_WCOLL = 3, K_EDATA = 4, K_EBUSY = 5;

    typedef struct {
        int          cyc;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  we;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic        rsv_ready;
    logic        flush;
    logic        wcoll;

    logic [4:0]  e_raddr;
    logic [31:0] e_rdata;
    logic [0:0]  e_rbusy;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [0:0]  e_we;
    logic        unused_e_rdy;
    logic        unused_e_wcoll;

    exp_t q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ibex_register_file_mp #(.RV32E(1'b0), .NumRead(2), .NumWrite(2)) dut (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_valid_i(rsv_valid),
        .rsv_addr_i(rsv_addr), .rsv_ready_o(rsv_ready), .flush_i(flush), .wcoll_o(wcoll)
    );

    ibex_register_file_mp #(.RV32E(1'b1), .NumRead(1), .NumWrite(1)) dut_e (
        .clk_i(clk), .rst_i(rst), .raddr_i(e_raddr), .rdata_o(e_rdata), .rbusy_o(e_rbusy),
        .waddr_i(e_waddr), .wdata_i(e_wdata), .we_i(e_we), .rsv_valid_i(1'b0),
        .rsv_addr_i(5'd0), .rsv_ready_o(unused_e_rdy), .flush_i(1'b0), .wcoll_o(unused_e_wcoll)
    );

    function automatic string kname(input int kind);
        case (kind)
            K_RDATA: return "rdata";
            K_RBUSY: return "rbusy";
            K_RDY:   return "rsv_ready";
            K_WCOLL: return "wcoll";
            K_EDATA: return "e_rdata";
            default: return "e_rbusy";
        endcase
    endfunction

    task automatic expect_v(input int kind, input int port, input logic [31:0] val);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.port = port; e.val = val;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        we = '0; rsv_valid = 1'b0; flush = 1'b0; e_we = '0;
    endtask

    // Monitor: compares every expectation tagged with the current cycle.
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                logic [31:0] act;
                case (q[i].kind)
                    K_RDATA: act = rdata[32*q[i].port +: 32];
                    K_RBUSY: act = 32'(rbusy[q[i].port]);
                    K_RDY:   act = 32'(rsv_ready);
                    K_WCOLL: act = 32'(wcoll);
                    K_EDATA: act = e_rdata;
                    default: act = 32'(e_rbusy);
                endcase
                n_cmp++;
                if (q[i].cyc != cyc || act !== q[i].val) begin
                    n_bad++;
                    $display("FAIL %s[%0d] cyc %0d (due %0d): got %h expected %h",
                             kname(q[i].kind), q[i].port, cyc, q[i].cyc, act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        rst = 1'b1; raddr = '0; waddr = '0; wdata = '0; we = '0;
        rsv_valid = 1'b0; rsv_addr = '0; flush = 1'b0;
        e_raddr = '0; e_waddr = '0; e_wdata = '0; e_we = '0;

        // Write attempted while in reset must not land.
        we = 2'b01; waddr[4:0] = 5'd5; wdata[31:0] = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; we = '0;
        raddr[4:0] = 5'd5;
        expect_v(K_RDATA, 0, 0); expect_v(K_RBUSY, 0, 0);
        expect_v(K_WCOLL, 0, 0); expect_v(K_RDY, 0, 0);

        // Collision on R7: port1 wins, bypassed same cycle, flag one cycle later.
        tick(); we = 2'b11; waddr = {5'd7, 5'd7}; wdata = {32'h22, 32'h11}; raddr[4:0] = 5'd7;
        expect_v(K_RDATA, 0, 32'h22); expect_v(K_RBUSY, 0, 0); expect_v(K_WCOLL, 0, 0);
        tick(); expect_v(K_RDATA, 0, 32'h22); expect_v(K_WCOLL, 0, 1);
        tick(); expect_v(K_WCOLL, 0, 0);
        tick(); we = 2'b11; waddr = {5'd9, 5'd8}; wdata = {32'hB, 32'hA};
        tick(); raddr = {5'd9, 5'd8};
        expect_v(K_RDATA, 0, 32'hA); expect_v(K_RDATA, 1, 32'hB); expect_v(K_WCOLL, 0, 0);

        // Scoreboard reserve / WAW block / release.
        tick(); raddr[4:0] = 5'd3; rsv_valid = 1'b1; rsv_addr = 5'd3;
        expect_v(K_RDY, 0, 1); expect_v(K_RBUSY, 0, 0);
        tick(); rsv_valid = 1'b1; rsv_addr = 5'd3;
        expect_v(K_RBUSY, 0, 1); expect_v(K_RDY, 0, 0);
        tick(); we = 2'b01; waddr[4:0] = 5'd3; wdata[31:0] = 32'h5;
        expect_v(K_RBUSY, 0, 0); expect_v(K_RDATA, 0, 32'h5);
        tick(); expect_v(K_RBUSY, 0, 0); expect_v(K_RDATA, 0, 32'h5);

        // Same-cycle release and re-reserve: reserve wins.
        tick(); rsv_valid = 1'b1; rsv_addr = 5'd3; expect_v(K_RDY, 0, 1);
        tick(); expect_v(K_RBUSY, 0, 1);
        tick(); we = 2'b01; waddr[4:0] = 5'd3; wdata[31:0] = 32'h66;
        rsv_valid = 1'b1; rsv_addr = 5'd3; expect_v(K_RDY, 0, 1);
        tick(); expect_v(K_RBUSY, 0, 1); expect_v(K_RDATA, 0, 32'h66);

        // Flush clears every busy bit and blocks the concurrent reserve.
        tick(); rsv_valid = 1'b1; rsv_addr = 5'd1; expect_v(K_RDY, 0, 1);
        tick(); rsv_valid = 1'b1; rsv_addr = 5'd2; expect_v(K_RDY, 0, 1);
        tick(); rsv_valid = 1'b1; rsv_addr = 5'd9; expect_v(K_RDY, 0, 1);
        tick(); flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 5'd4; raddr = {5'd9, 5'd1};
        expect_v(K_RDY, 0, 0); expect_v(K_RBUSY, 0, 1); expect_v(K_RBUSY, 1, 1);
        tick(); raddr = {5'd2, 5'd1}; expect_v(K_RBUSY, 0, 0); expect_v(K_RBUSY, 1, 0);
        tick(); raddr = {5'd9, 5'd4};
        expect_v(K_RBUSY, 0, 0); expect_v(K_RBUSY, 1, 0); expect_v(K_RDATA, 1, 32'hB);
        tick(); raddr = {5'd7, 5'd3};
        expect_v(K_RBUSY, 0, 0); expect_v(K_RDATA, 0, 32'h66); expect_v(K_RDATA, 1, 32'h22);

        // R0 is hardwired.
        tick(); we = 2'b01; waddr[4:0] = 5'd0; wdata[31:0] = 32'hFFFF; raddr[4:0] = 5'd0;
        expect_v(K_RDATA, 0, 0);
        tick(); expect_v(K_RDATA, 0, 0); rsv_valid = 1'b1; rsv_addr = 5'd0; expect_v(K_RDY, 0, 1);
        tick(); expect_v(K_RBUSY, 0, 0); rsv_valid = 1'b1; rsv_addr = 5'd0; expect_v(K_RDY, 0, 1);

        // RV32E instance: R20 must not alias onto R4.
        tick(); e_we = 1'b1; e_waddr = 5'd4; e_wdata = 32'h55;
        tick(); e_we = 1'b1; e_waddr = 5'd20; e_wdata = 32'h1234; e_raddr = 5'd20;
        expect_v(K_EDATA, 0, 0); expect_v(K_EBUSY, 0, 0);
        tick(); e_raddr = 5'd4; expect_v(K_EDATA, 0, 32'h55);
        tick(); e_raddr = 5'd20; expect_v(K_EDATA, 0, 0);

        // Asynchronous reset mid-cycle wipes state immediately.
        tick(); we = 2'b01; waddr[4:0] = 5'd6; wdata[31:0] = 32'h77;
        tick(); raddr = {5'd7, 5'd6}; expect_v(K_RDATA, 0, 32'h77); expect_v(K_RDATA, 1, 32'h22);
        tick(); #1; rst = 1'b1;
        expect_v(K_RDATA, 0, 0); expect_v(K_RDATA, 1, 0); expect_v(K_RBUSY, 0, 0);
        tick(); rst = 1'b0; expect_v(K_RDATA, 0, 0);

        tick(); tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked expectations, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
